// File: rtl/dmac_pkg.sv
// Register map offsets and field positions shared by the DMA controller register bank.
package dmac_pkg;

  localparam logic [11:0] CFG       = 12'h030;
  localparam logic [11:0] INT_STAT  = 12'h000;
  localparam logic [11:0] INT_CLR   = 12'h008;
  localparam logic [11:0] CH_BASE   = 12'h100;
  localparam logic [11:0] CH_STRIDE = 12'h020;

  localparam logic [11:0] SRC  = 12'h000;
  localparam logic [11:0] DST  = 12'h004;
  localparam logic [11:0] CTRL = 12'h00C;
  localparam logic [11:0] CCFG = 12'h010;

  localparam int GCFG_EN_BIT   = 0;
  localparam int CCFG_EN_BIT   = 0;
  localparam int CCFG_MASK_BIT = 1;
  localparam int CCFG_PEND_BIT = 2;
  localparam int CTRL_TS_LSB   = 0;
  localparam int CTRL_BS_LSB   = 12;

  function automatic logic [11:0] ch_reg_addr(input int unsigned ch, input logic [11:0] off);
    return CH_BASE + 12'(ch) * CH_STRIDE + off;
  endfunction

endpackage

// File: rtl/dmac_ch_regs.sv
// One channel's programmable registers (Src/Dst/Ctrl/Cfg) with write decode,
// W1C pend clearing and slave-over-engine collision handling.
module dmac_ch_regs
  import dmac_pkg::*;
#(
  parameter int CH_IDX = 0,
  parameter int TS_W   = 12,
  parameter int BS_W   = 3
) (
  input  logic            r_HCLK,
  input  logic            r_HRESETn,
  input  logic [11:0]     haddr,
  input  logic [31:0]     wdata,
  input  logic            write_en,
  input  logic            ch_dis,
  input  logic            set_intr,
  output logic [31:0]     src,
  output logic [31:0]     dst,
  output logic [TS_W-1:0] ts,
  output logic [BS_W-1:0] bs,
  output logic            en,
  output logic            mask,
  output logic            pend,
  output logic [31:0]     rdata
);

  localparam logic [11:0] A_SRC  = ch_reg_addr(CH_IDX, SRC);
  localparam logic [11:0] A_DST  = ch_reg_addr(CH_IDX, DST);
  localparam logic [11:0] A_CTRL = ch_reg_addr(CH_IDX, CTRL);
  localparam logic [11:0] A_CCFG = ch_reg_addr(CH_IDX, CCFG);

  logic wr_src, wr_dst, wr_ctrl, wr_cfg, clr_pend;

  assign wr_src   = write_en && (haddr == A_SRC);
  assign wr_dst   = write_en && (haddr == A_DST);
  assign wr_ctrl  = write_en && (haddr == A_CTRL);
  assign wr_cfg   = write_en && (haddr == A_CCFG);
  assign clr_pend = write_en && (haddr == INT_CLR) && wdata[CH_IDX];

  always_ff @(posedge r_HCLK or negedge r_HRESETn) begin
    if (!r_HRESETn) begin
      src  <= '0;
      dst  <= '0;
      ts   <= '0;
      bs   <= '0;
      en   <= 1'b0;
      mask <= 1'b0;
      pend <= 1'b0;
    end else begin
      if (wr_src)  src <= wdata;
      if (wr_dst)  dst <= wdata;
      if (wr_ctrl) begin
        ts <= wdata[CTRL_TS_LSB +: TS_W];
        bs <= wdata[CTRL_BS_LSB +: BS_W];
      end
      // A slave Cfg write replaces the whole word, so engine updates that cycle are lost.
      if (wr_cfg) begin
        en   <= wdata[CCFG_EN_BIT];
        mask <= wdata[CCFG_MASK_BIT];
        pend <= wdata[CCFG_PEND_BIT];
      end else begin
        if (ch_dis) en <= 1'b0;
        if (set_intr)      pend <= 1'b1;
        else if (clr_pend) pend <= 1'b0;
      end
    end
  end

  always_comb begin
    rdata = '0;
    case (haddr)
      A_SRC:  rdata = src;
      A_DST:  rdata = dst;
      A_CTRL: begin
        rdata[CTRL_TS_LSB +: TS_W] = ts;
        rdata[CTRL_BS_LSB +: BS_W] = bs;
      end
      A_CCFG: begin
        rdata[CCFG_EN_BIT]   = en;
        rdata[CCFG_MASK_BIT] = mask;
        rdata[CCFG_PEND_BIT] = pend;
      end
      default: rdata = '0;
    endcase
  end

endmodule

// File: rtl/dmac_reg_bank_mc.sv
// Multi-channel DMA register bank: global regs, per-channel banks, live engine
// copies of the active channel, slave read-back and the DMACINTR output.
module dmac_reg_bank_mc
  import dmac_pkg::*;
#(
  parameter int NUM_CH    = 2,
  parameter int TS_W      = 12,
  parameter int BS_W      = 3,
  parameter int BUF_DEPTH = 4,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int IDX_W = $clog2(BUF_DEPTH)
) (
  input  logic              r_HCLK,
  input  logic              r_HRESETn,
  input  logic [31:0]       r_HADDR,
  input  logic [31:0]       r_HWDATA,
  output logic [31:0]       r_HRDATA,
  input  logic              load_ahb_addr,
  input  logic              write_out_reg,
  input  logic              read_out_reg,
  input  logic [CH_W-1:0]   ch_sel,
  input  logic              load_ch_addr,
  input  logic              src_addr_inc,
  input  logic              dest_addr_inc,
  input  logic              src_burst_zero,
  input  logic              dest_burst_zero,
  input  logic              ts_dec,
  input  logic              buf_idx_inc,
  input  logic              buf_zero,
  input  logic              ch_dis,
  input  logic              set_intr,
  input  logic              m_HGRANT,
  output logic              sync_grant,
  output logic [NUM_CH-1:0] ch_enable,
  output logic [31:0]       src_addr_m,
  output logic [31:0]       dest_addr_m,
  output logic [TS_W-1:0]   ts_cur,
  output logic              ts_zero,
  output logic [BS_W-1:0]   bs_cur,
  output logic [BS_W:0]     src_burst_cnt,
  output logic [BS_W:0]     dest_burst_cnt,
  output logic              burst_last,
  output logic [IDX_W-1:0]  buf_idx,
  output logic              DMACINTR
);

  localparam int CNT_W = BS_W + 1;

  logic [11:0]       haddr_q;
  logic              global_en;
  logic [NUM_CH-1:0] sel, en_r, mask_r, pend_r;
  logic [31:0]       src_r    [NUM_CH];
  logic [31:0]       dst_r    [NUM_CH];
  logic [TS_W-1:0]   ts_r     [NUM_CH];
  logic [BS_W-1:0]   bs_r     [NUM_CH];
  logic [31:0]       ch_rdata [NUM_CH];

  // Only the low 12 address bits select a register.
  logic unused_haddr_hi;
  assign unused_haddr_hi = ^r_HADDR[31:12];

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    assign sel[ch] = (ch_sel == CH_W'(ch));

    dmac_ch_regs #(
      .CH_IDX (ch),
      .TS_W   (TS_W),
      .BS_W   (BS_W)
    ) u_ch_regs (
      .r_HCLK    (r_HCLK),
      .r_HRESETn (r_HRESETn),
      .haddr     (haddr_q),
      .wdata     (r_HWDATA),
      .write_en  (write_out_reg),
      .ch_dis    (ch_dis && sel[ch]),
      .set_intr  (set_intr && sel[ch]),
      .src       (src_r[ch]),
      .dst       (dst_r[ch]),
      .ts        (ts_r[ch]),
      .bs        (bs_r[ch]),
      .en        (en_r[ch]),
      .mask      (mask_r[ch]),
      .pend      (pend_r[ch]),
      .rdata     (ch_rdata[ch])
    );
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge r_HCLK or negedge r_HRESETn) begin
    if (!r_HRESETn) begin
      haddr_q    <= '0;
      global_en  <= 1'b0;
      sync_grant <= 1'b0;
    end else begin
      if (load_ahb_addr) haddr_q <= r_HADDR[11:0];
      if (write_out_reg && (haddr_q == CFG)) global_en <= r_HWDATA[GCFG_EN_BIT];
      sync_grant <= m_HGRANT;
    end
  end

  logic [31:0]     sel_src, sel_dst;
  logic [TS_W-1:0] sel_ts;
  logic [BS_W-1:0] sel_bs;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    sel_src = '0;
    sel_dst = '0;
    sel_ts  = '0;
    sel_bs  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (sel[i]) begin
        sel_src = src_r[i];
        sel_dst = dst_r[i];
        sel_ts  = ts_r[i];
        sel_bs  = bs_r[i];
      end
    end
  end

  logic [TS_W-1:0] ts_next;
  assign ts_next = (ts_cur > TS_W'(4)) ? ts_cur - TS_W'(4) : '0;

  always_ff @(posedge r_HCLK or negedge r_HRESETn) begin
    if (!r_HRESETn) begin
      src_addr_m     <= '0;
      dest_addr_m    <= '0;
      ts_cur         <= '0;
      bs_cur         <= '0;
      src_burst_cnt  <= '0;
      dest_burst_cnt <= '0;
    end else if (load_ch_addr) begin
      src_addr_m     <= {sel_src[31:2], 2'b00};
      dest_addr_m    <= {sel_dst[31:2], 2'b00};
      ts_cur         <= sel_ts;
      bs_cur         <= sel_bs;
      src_burst_cnt  <= '0;
      dest_burst_cnt <= '0;
    end else begin
      if (src_addr_inc)  src_addr_m  <= src_addr_m + 32'd4;
      if (dest_addr_inc) dest_addr_m <= dest_addr_m + 32'd4;
      if (src_burst_zero)    src_burst_cnt <= '0;
      else if (src_addr_inc) src_burst_cnt <= src_burst_cnt + CNT_W'(1);
      if (dest_burst_zero)    dest_burst_cnt <= '0;
      else if (dest_addr_inc) dest_burst_cnt <= dest_burst_cnt + CNT_W'(1);
      if (ts_dec) ts_cur <= ts_next;
    end
  end

  always_ff @(posedge r_HCLK or negedge r_HRESETn) begin
    if (!r_HRESETn) begin
      buf_idx <= '0;
    end else if (buf_zero) begin
      buf_idx <= '0;
    end else if (buf_idx_inc) begin
      buf_idx <= (buf_idx == IDX_W'(BUF_DEPTH - 1)) ? '0 : buf_idx + IDX_W'(1);
    end
  end

  assign ts_zero    = (ts_cur == '0);
  assign burst_last = ({{(32-CNT_W){1'b0}}, dest_burst_cnt} == ((32'd1 << bs_cur) - 32'd1));
  assign ch_enable  = en_r & {NUM_CH{global_en}};
  assign DMACINTR   = |(pend_r & mask_r);

  always_comb begin
    r_HRDATA = '0;
    if (read_out_reg) begin
      if (haddr_q == INT_STAT) r_HRDATA[NUM_CH-1:0] = pend_r;
      else if (haddr_q == CFG) r_HRDATA[GCFG_EN_BIT] = global_en;
      for (int i = 0; i < NUM_CH; i++) r_HRDATA = r_HRDATA | ch_rdata[i];
    end
  end

endmodule

// File: tb/tb_dmac_reg_bank_mc.sv
// Self-checking bench for dmac_reg_bank_mc: a register-map model compared every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_dmac_reg_bank_mc;

  localparam int NUM_CH    = 2;
  localparam int TS_W      = 12;
  localparam int BS_W      = 3;
  localparam int BUF_DEPTH = 4;

  logic        r_HCLK = 1'b0;
  logic        r_HRESETn = 1'b0;
  logic [31:0] r_HADDR = '0, r_HWDATA = '0;
  logic [31:0] r_HRDATA;
  logic        load_ahb_addr = 0, write_out_reg = 0, read_out_reg = 0;
  logic [0:0]  ch_sel = '0;
  logic        load_ch_addr = 0, src_addr_inc = 0, dest_addr_inc = 0;
  logic        src_burst_zero = 0, dest_burst_zero = 0, ts_dec = 0;
  logic        buf_idx_inc = 0, buf_zero = 0, ch_dis = 0, set_intr = 0, m_HGRANT = 0;
  logic        sync_grant, ts_zero, burst_last, DMACINTR;
  logic [NUM_CH-1:0] ch_enable;
  logic [31:0] src_addr_m, dest_addr_m;
  logic [TS_W-1:0] ts_cur;
  logic [BS_W-1:0] bs_cur;
  logic [BS_W:0]   src_burst_cnt, dest_burst_cnt;
  logic [1:0]      buf_idx;

  dmac_reg_bank_mc #(.NUM_CH(NUM_CH), .TS_W(TS_W), .BS_W(BS_W), .BUF_DEPTH(BUF_DEPTH)) dut (
    .r_HCLK(r_HCLK), .r_HRESETn(r_HRESETn), .r_HADDR(r_HADDR), .r_HWDATA(r_HWDATA),
    .r_HRDATA(r_HRDATA), .load_ahb_addr(load_ahb_addr), .write_out_reg(write_out_reg),
    .read_out_reg(read_out_reg), .ch_sel(ch_sel), .load_ch_addr(load_ch_addr),
    .src_addr_inc(src_addr_inc), .dest_addr_inc(dest_addr_inc),
    .src_burst_zero(src_burst_zero), .dest_burst_zero(dest_burst_zero), .ts_dec(ts_dec),
    .buf_idx_inc(buf_idx_inc), .buf_zero(buf_zero), .ch_dis(ch_dis), .set_intr(set_intr),
    .m_HGRANT(m_HGRANT), .sync_grant(sync_grant), .ch_enable(ch_enable),
    .src_addr_m(src_addr_m), .dest_addr_m(dest_addr_m), .ts_cur(ts_cur), .ts_zero(ts_zero),
    .bs_cur(bs_cur), .src_burst_cnt(src_burst_cnt), .dest_burst_cnt(dest_burst_cnt),
    .burst_last(burst_last), .buf_idx(buf_idx), .DMACINTR(DMACINTR)
  );

  always #5 r_HCLK = ~r_HCLK;

  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_en   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model: registers as words, counters as integers
  logic [31:0] m_src [NUM_CH];
  logic [31:0] m_dst [NUM_CH];
  logic [31:0] m_ctrl[NUM_CH];
  logic [2:0]  m_cfg [NUM_CH];   // {pend, mask, en}
  logic        m_gen, m_grant;
  logic [11:0] m_haddr;
  logic [31:0] m_sa, m_da;
  int          m_ts, m_bs, m_sc, m_dc, m_buf;

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_src[c] = '0; m_dst[c] = '0; m_ctrl[c] = '0; m_cfg[c] = '0;
    end
    m_gen = 0; m_grant = 0; m_haddr = '0; m_sa = '0; m_da = '0;
    m_ts = 0; m_bs = 0; m_sc = 0; m_dc = 0; m_buf = 0;
  endtask

  task automatic model_write(input logic [11:0] a, input logic [31:0] d);
    int c, off;
    if (a == 12'h030) m_gen = d[0];
    else if (a >= 12'h100) begin
      c   = (int'(a) - 256) / 32;
      off = (int'(a) - 256) % 32;
      if (c < NUM_CH) begin
        case (off)
          0:  m_src[c]  = d;
          4:  m_dst[c]  = d;
          12: m_ctrl[c] = d & 32'h0000_7FFF;
          16: m_cfg[c]  = d[2:0];
          default: ;
        endcase
      end
    end
  endtask

  function automatic logic [31:0] model_read(input logic [11:0] a);
    int c, off;
    logic [31:0] r = '0;
    if (a == 12'h000) begin
      for (int k = 0; k < NUM_CH; k++) r[k] = m_cfg[k][2];
    end else if (a == 12'h030) r = {31'b0, m_gen};
    else if (a >= 12'h100) begin
      c   = (int'(a) - 256) / 32;
      off = (int'(a) - 256) % 32;
      if (c < NUM_CH) begin
        case (off)
          0:  r = m_src[c];
          4:  r = m_dst[c];
          12: r = m_ctrl[c];
          16: r = {29'b0, m_cfg[c]};
          default: r = '0;
        endcase
      end
    end
    return r;
  endfunction

  task automatic model_step();
    if (load_ch_addr) begin
      m_sa = m_src[ch_sel] & ~32'h3;
      m_da = m_dst[ch_sel] & ~32'h3;
      m_ts = int'(m_ctrl[ch_sel] & 32'hFFF);
      m_bs = int'((m_ctrl[ch_sel] >> 12) & 32'h7);
      m_sc = 0; m_dc = 0;
    end else begin
      if (src_addr_inc)  m_sa = m_sa + 32'd4;
      if (dest_addr_inc) m_da = m_da + 32'd4;
      if (src_burst_zero) m_sc = 0; else if (src_addr_inc) m_sc = (m_sc + 1) % 16;
      if (dest_burst_zero) m_dc = 0; else if (dest_addr_inc) m_dc = (m_dc + 1) % 16;
      if (ts_dec) m_ts = (m_ts < 4) ? 0 : m_ts - 4;
    end
    if (buf_zero) m_buf = 0; else if (buf_idx_inc) m_buf = (m_buf + 1) % BUF_DEPTH;
    // engine effects first, then any slave write to the same word overrides them
    if (write_out_reg && m_haddr == 12'h008)
      for (int c = 0; c < NUM_CH; c++) if (r_HWDATA[c]) m_cfg[c][2] = 1'b0;
    if (set_intr) m_cfg[ch_sel][2] = 1'b1;
    if (ch_dis)   m_cfg[ch_sel][0] = 1'b0;
    if (write_out_reg) model_write(m_haddr, r_HWDATA);
    if (load_ahb_addr) m_haddr = r_HADDR[11:0];
    m_grant = m_HGRANT;
  endtask

  function automatic logic [31:0] model_enable();
    logic [31:0] v = '0;
    for (int c = 0; c < NUM_CH; c++) v[c] = m_cfg[c][0] & m_gen;
    return v;
  endfunction

  function automatic logic model_intr();
    logic v = 1'b0;
    for (int c = 0; c < NUM_CH; c++) v = v | (m_cfg[c][2] & m_cfg[c][1]);
    return v;
  endfunction

  always @(negedge r_HRESETn) model_reset();
  always @(posedge r_HCLK) if (r_HRESETn) model_step();

  always @(negedge r_HCLK) begin
    if (cmp_en) begin
      check("r_HRDATA",       r_HRDATA, read_out_reg ? model_read(m_haddr) : 32'h0);
      check("sync_grant",     {31'b0, sync_grant}, {31'b0, m_grant});
      check("ch_enable",      32'(ch_enable), model_enable());
      check("src_addr_m",     src_addr_m, m_sa);
      check("dest_addr_m",    dest_addr_m, m_da);
      check("ts_cur",         32'(ts_cur), 32'(m_ts));
      check("ts_zero",        {31'b0, ts_zero}, {31'b0, m_ts == 0});
      check("bs_cur",         32'(bs_cur), 32'(m_bs));
      check("src_burst_cnt",  32'(src_burst_cnt), 32'(m_sc));
      check("dest_burst_cnt", 32'(dest_burst_cnt), 32'(m_dc));
      check("burst_last",     {31'b0, burst_last}, {31'b0, m_dc == (1 << m_bs) - 1});
      check("buf_idx",        32'(buf_idx), 32'(m_buf));
      check("DMACINTR",       {31'b0, DMACINTR}, {31'b0, model_intr()});
    end
  end

  // ---------------- stimulus helpers
  task automatic cyc();
    @(posedge r_HCLK);
    #1;
    load_ahb_addr = 0; write_out_reg = 0; read_out_reg = 0; load_ch_addr = 0;
    src_addr_inc = 0; dest_addr_inc = 0; src_burst_zero = 0; dest_burst_zero = 0;
    ts_dec = 0; buf_idx_inc = 0; buf_zero = 0; ch_dis = 0; set_intr = 0;
  endtask

  task automatic set_addr(input logic [31:0] a);
    r_HADDR = a; load_ahb_addr = 1; cyc();
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    set_addr(a);
    r_HWDATA = d; write_out_reg = 1; cyc();
  endtask

  task automatic rd(input string name, input logic [31:0] a, input logic [31:0] exp);
    set_addr(a);
    read_out_reg = 1; #1;
    check(name, r_HRDATA, exp);
    cyc();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    model_reset();
    cmp_en = 1;
    cyc(); cyc();
    check("reset src_addr_m", src_addr_m, 32'h0);
    check("reset DMACINTR",   {31'b0, DMACINTR}, 32'h0);
    check("reset sync_grant", {31'b0, sync_grant}, 32'h0);
    r_HRESETn = 1;
    cyc();

    // program channel 1 and load it into the engine
    wr(32'h120, 32'h1000_0003);
    wr(32'h124, 32'h3000_0007);
    wr(32'h12C, 32'h0000_2010);
    wr(32'h130, 32'h0000_0003);
    wr(32'h030, 32'h0000_0001);
    ch_sel = 1'b1; load_ch_addr = 1; cyc();
    check("load src_addr_m",  src_addr_m, 32'h1000_0000);
    check("load dest_addr_m", dest_addr_m, 32'h3000_0004);
    check("load ts_cur",      32'(ts_cur), 32'd16);
    check("load bs_cur",      32'(bs_cur), 32'd2);
    check("load ch_enable",   32'(ch_enable), 32'h2);

    for (int k = 1; k <= 4; k++) begin
      ts_dec = 1; src_addr_inc = 1; dest_addr_inc = 1; cyc();
      if (k == 3) check("burst_last after 3 beats", {31'b0, burst_last}, 32'h1);
    end
    check("ts_zero after 4 dec",   {31'b0, ts_zero}, 32'h1);
    check("src_addr_m after 4",    src_addr_m, 32'h1000_0010);
    check("burst_last after 4",    {31'b0, burst_last}, 32'h0);
    ts_dec = 1; cyc();
    check("ts_dec at zero",        32'(ts_cur), 32'h0);

    // saturation from TS=2, and BS=0 single-beat burst
    wr(32'h10C, 32'h0000_0002);
    ch_sel = 1'b0; load_ch_addr = 1; cyc();
    check("bs0 burst_last", {31'b0, burst_last}, 32'h1);
    ts_dec = 1; cyc();
    check("ts 2 saturates", 32'(ts_cur), 32'h0);

    // interrupts
    ch_sel = 1'b1; set_intr = 1; cyc();
    check("intr set", {31'b0, DMACINTR}, 32'h1);
    rd("read IntStatus", 32'h000, 32'h2);
    rd("read ch1 cfg", 32'h130, 32'h7);
    wr(32'h008, 32'h2);
    check("intr W1C", {31'b0, DMACINTR}, 32'h0);
    set_addr(32'h008);
    r_HWDATA = 32'h2; write_out_reg = 1; set_intr = 1; cyc();
    check("set wins over W1C", {31'b0, DMACINTR}, 32'h1);
    wr(32'h008, 32'h2);

    // slave write beats engine update
    set_addr(32'h130);
    r_HWDATA = 32'h1; write_out_reg = 1; ch_dis = 1; cyc();
    check("cfg write beats ch_dis", 32'(ch_enable), 32'h2);
    rd("ch1 cfg after collision", 32'h130, 32'h1);
    ch_dis = 1; cyc();
    check("ch_dis alone", 32'(ch_enable), 32'h0);
    set_addr(32'h130);
    r_HWDATA = 32'h3; write_out_reg = 1; set_intr = 1; cyc();
    rd("cfg write beats set_intr", 32'h130, 32'h3);

    // ignored writes and unused bits
    wr(32'h0FC, 32'hFFFF_FFFF);
    rd("0x0FC write harmless", 32'h120, 32'h1000_0003);
    rd("unmapped reads 0", 32'h0FC, 32'h0);
    wr(32'h140, 32'h1234_5678);
    rd("ch2 window ignored", 32'h140, 32'h0);
    wr(32'h000, 32'hFF);
    rd("IntStatus RO", 32'h000, 32'h0);
    rd("global cfg kept", 32'h030, 32'h1);
    wr(32'h12C, 32'hFFFF_FFFF);
    rd("ctrl unused bits 0", 32'h12C, 32'h7FFF);

    // address wrap, burst_zero and load priority
    wr(32'h100, 32'hFFFF_FFFE);
    ch_sel = 1'b0; load_ch_addr = 1; cyc();
    check("wrap start", src_addr_m, 32'hFFFF_FFFC);
    src_addr_inc = 1; cyc();
    check("addr wraps", src_addr_m, 32'h0);
    src_addr_inc = 1; src_burst_zero = 1; cyc();
    check("burst_zero cnt", 32'(src_burst_cnt), 32'h0);
    check("burst_zero addr", src_addr_m, 32'h4);
    load_ch_addr = 1; src_addr_inc = 1; ts_dec = 1; cyc();
    check("load beats inc", src_addr_m, 32'hFFFF_FFFC);
    check("load beats dec", 32'(ts_cur), 32'h2);

    // buffer index
    for (int k = 0; k < 4; k++) begin buf_idx_inc = 1; cyc(); end
    check("buf_idx wraps", 32'(buf_idx), 32'h0);
    buf_idx_inc = 1; cyc(); buf_idx_inc = 1; cyc();
    buf_idx_inc = 1; buf_zero = 1; cyc();
    check("buf_zero priority", 32'(buf_idx), 32'h0);

    m_HGRANT = 1; cyc();
    check("sync_grant", {31'b0, sync_grant}, 32'h1);

    // asynchronous reset mid-run
    wr(32'h100, 32'h2000_0010);
    load_ch_addr = 1; buf_idx_inc = 1; cyc();
    check("pre-reset src_addr_m", src_addr_m, 32'h2000_0010);
    #1 r_HRESETn = 0;
    #1;
    check("async rst src_addr_m", src_addr_m, 32'h0);
    check("async rst ts_cur",     32'(ts_cur), 32'h0);
    check("async rst buf_idx",    32'(buf_idx), 32'h0);
    check("async rst sync_grant", {31'b0, sync_grant}, 32'h0);
    check("async rst ch_enable",  32'(ch_enable), 32'h0);
    cyc(); cyc();
    r_HRESETn = 1;
    cyc(); cyc();

    cmp_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
